cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Gates the write enables so that the combinational decode outputs take effect only in the correct cycle.
- Owns the single shared memory port handshake for instruction fetch and data access.
- Traps unsupported instructions and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16'd1024: cycles that mem_req may wait without mem_ready before the block enters ERROR. 0 disables the timeout.
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- stall  in  1  external hold, honoured only in FETCH
- mem_req  out  1  memory request
- mem_is_data  out  1  0 = instruction fetch, 1 = data access
- mem_we  out  1  data write (stores)
- ir_wren  out  1  latch fetched word into the instruction register
- pc_wren  out  1  PC update strobe
- pc_src  out  2  00 PC+4, 01 jump target, 10 branch target, 11 register (jr)
- reg_file_wren  out  1  register file write strobe
- state  out  3  current state
- illegal  out  1  sticky: unsupported instruction trapped
- timeout  out  1  sticky: memory timeout
- retired_count  out  CNT_W  instructions completed; wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, active-high): next state is FETCH.
  - All strobes are 0, pc_src=00, illegal=0, timeout=0, retired_count=0, timeout counter=0.
  - Reset in any state, including mid-MEM, abandons the transaction; mem_req is low in the cycle after the reset edge.
- A handshake completes on any edge where mem_req=1 and mem_ready=1.
  - mem_req stays high until completion.
  - mem_ready while mem_req=0 is ignored.
- FETCH:
  - mem_req=!stall, mem_is_data=0.
  - On completion, ir_wren=1, pc_wren=1 and pc_src=00 in that same cycle (Mealy), and the next state is DECODE.
  - If stall=1: no request, no progress, timeout counter held.
- DECODE: one cycle. Classifies opcode/funct.
  - Illegal → ERROR, illegal=1.
  - Otherwise → EXECUTE.
- Legal set:
  - opcode 0 with funct in {0,2,3,8,32,33,34,35,36,37,38,39,42}.
  - opcode in {2,3,4,5,8,9,10,12,13,35,40,41,43}.
  - Everything else (lui, lb, lh, lbu, lhu, mult/div/mfhi/mflo, …) is illegal.
- EXECUTE: one cycle.
  - j (2) and jal (3): pc_wren=1, pc_src=01.
  - jr (op 0, funct 8): pc_wren=1, pc_src=11.
  - beq (4): pc_wren=alu_zero. bne (5): pc_wren=!alu_zero. pc_src=10 in both cases.
  - Next state:
    - lw or store (35, 40, 41, 43) → MEM.
    - Writers → WRITEBACK.
    - j, jr, beq, bne → FETCH, and retired_count increments.
- MEM: mem_req=1, mem_is_data=1, mem_we=1 for stores.
  - On completion, lw → WRITEBACK.
  - On completion, a store → FETCH and retired_count increments.
- WRITEBACK: one cycle. reg_file_wren=1, retired_count increments, next state FETCH.
  - Writers: R-type except jr, jal, addi, addiu, slti, andi, ori, lw.
  - j does not write the register file.
- reg_file_wren and mem_we are never asserted outside WRITEBACK and MEM respectively.
- Timeout counter (16-bit):
  - Increments each cycle that mem_req=1 and mem_ready=0.
  - Clears on completion and on every state change.
  - When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is ERROR and timeout=1.
- ERROR: all strobes 0; holds until reset.
- Minimum latency with mem_ready=1 immediately:
  - ALU op: 4 cycles.
  - lw: 5 cycles.
  - Store: 4 cycles.
  - Branch/jump: 3 cycles.

Decomposition:
- Package cpu_seq_pkg:
  - State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, ERROR=5.
  - pc_src constants.
  - Opcode and funct constants.
- Sub-module cpu_seq_decode (combinational): opcode/funct → is_legal, is_writer, is_load, is_store, is_jump, is_jr, is_beq, is_bne.
- The FSM and counters live in cpu_sequencer.

Test Plan:
- reset, mem_ready=1, IR = addu (op 0, funct 33):
  - state sequence 0,1,2,4,0.
  - ir_wren and pc_wren with pc_src=00 in cycle 1; reg_file_wren in cycle 4 only.
  - retired_count=1.
- lw (op 35), mem_ready held low for the first 3 MEM cycles: mem_req, mem_is_data=1 and mem_we=0 held for 4 cycles, then WRITEBACK with reg_file_wren=1.
- beq (op 4) with alu_zero=1, then beq with alu_zero=0:
  - first gives pc_wren=1, pc_src=10 in EXECUTE;
  - second gives pc_wren=0; both return to FETCH.
- sw (op 43): mem_we=1 in MEM, no reg_file_wren, retired_count increments on MEM completion.
- lui (op 15): DECODE → ERROR, illegal=1; strobes stay 0 for 20 cycles; reset clears illegal.
- MEM_TIMEOUT=4 and mem_ready never asserted in FETCH: ERROR on the 4th request cycle, timeout=1.
- Reset asserted mid-MEM: FETCH next, with mem_req=0 in the cycle after the reset edge.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: state codes,
// PC source select values and the opcode/funct values the decoder recognises.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_ERROR     = 3'd5
  } seq_state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;

  function automatic logic rtype_funct_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_JR,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: rtype_funct_legal = 1'b1;
      default:                                rtype_funct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction classifier. Every class output is qualified by
// legality, so an unsupported encoding asserts nothing but !is_legal.
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_legal,
  output logic       is_writer,
  output logic       is_load,
  output logic       is_store,
  output logic       is_jump,
  output logic       is_jr,
  output logic       is_beq,
  output logic       is_bne
);

  always_comb begin
    is_legal  = 1'b0;
    is_writer = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_legal  = rtype_funct_legal(funct);
        is_jr     = (funct == FN_JR);
        is_writer = rtype_funct_legal(funct) && (funct != FN_JR);
      end
      OP_J: begin
        is_legal = 1'b1;
        is_jump  = 1'b1;
      end
      // jal both redirects the PC and writes the link register
      OP_JAL: begin
        is_legal  = 1'b1;
        is_jump   = 1'b1;
        is_writer = 1'b1;
      end
      OP_BEQ: begin
        is_legal = 1'b1;
        is_beq   = 1'b1;
      end
      OP_BNE: begin
        is_legal = 1'b1;
        is_bne   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
        is_legal  = 1'b1;
        is_writer = 1'b1;
      end
      OP_LW: begin
        is_legal  = 1'b1;
        is_load   = 1'b1;
        is_writer = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        is_legal = 1'b1;
        is_store = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the shared memory handshake, gates the
// datapath write strobes to the right cycle, traps bad encodings and counts retires.
//
// state     | meaning
// FETCH     | instruction read on the shared memory port, held off by stall
// DECODE    | classify opcode/funct, trap unsupported encodings
// EXECUTE   | resolve jumps and branches, pick MEM / WRITEBACK / FETCH
// MEM       | data read (lw) or write (sb/sh/sw)
// WRITEBACK | register file write, instruction retires
// ERROR     | trapped on illegal encoding or memory timeout, held until reset
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [15:0] MEM_TIMEOUT = 16'd1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  input  logic             stall,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             mem_we,
  output logic             ir_wren,
  output logic             pc_wren,
  output logic [1:0]       pc_src,
  output logic             reg_file_wren,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired_count
);

  seq_state_e       state_q, state_d;
  logic [15:0]      tmo_cnt_q, tmo_cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic is_legal, is_writer, is_load, is_store;
  logic is_jump, is_jr, is_beq, is_bne;
  logic retire, handshake, tmo_expire;

  cpu_seq_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .is_legal  (is_legal),
    .is_writer (is_writer),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_jump   (is_jump),
    .is_jr     (is_jr),
    .is_beq    (is_beq),
    .is_bne    (is_bne)
  );

  always_comb begin
    mem_req       = 1'b0;
    mem_is_data   = 1'b0;
    mem_we        = 1'b0;
    ir_wren       = 1'b0;
    pc_wren       = 1'b0;
    pc_src        = PC_SRC_SEQ;
    reg_file_wren = 1'b0;
    state_d       = state_q;
    illegal_d     = illegal_q;
    retire        = 1'b0;
    // Strobes stay quiet while reset is held, so an abandoned transfer is not re-requested
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = !stall;
          if (!stall && mem_ready) begin
            ir_wren = 1'b1;
            pc_wren = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_legal) begin
            state_d = ST_EXECUTE;
          end else begin
            state_d   = ST_ERROR;
            illegal_d = 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (is_jump) begin
            pc_wren = 1'b1;
            pc_src  = PC_SRC_JUMP;
          end else if (is_jr) begin
            pc_wren = 1'b1;
            pc_src  = PC_SRC_REG;
          end else if (is_beq) begin
            pc_wren = alu_zero;
            pc_src  = PC_SRC_BRANCH;
          end else if (is_bne) begin
            pc_wren = !alu_zero;
            pc_src  = PC_SRC_BRANCH;
          end
          if (is_load || is_store) begin
            state_d = ST_MEM;
          end else if (is_writer) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req     = 1'b1;
          mem_is_data = 1'b1;
          mem_we      = is_store;
          if (mem_ready) begin
            state_d = is_load ? ST_WRITEBACK : ST_FETCH;
            retire  = !is_load;
          end
        end
        ST_WRITEBACK: begin
          reg_file_wren = 1'b1;
          retire        = 1'b1;
          state_d       = ST_FETCH;
        end
        default: state_d = ST_ERROR;
      endcase
    end

    handshake  = mem_req && mem_ready;
    tmo_expire = (MEM_TIMEOUT != 16'd0) && mem_req && !mem_ready &&
                 (tmo_cnt_q == MEM_TIMEOUT - 16'd1);
    timeout_d  = timeout_q;
    if (tmo_expire) begin
      state_d   = ST_ERROR;
      timeout_d = 1'b1;
    end

    if (handshake || (state_d != state_q)) begin
      tmo_cnt_d = 16'd0;
    end else if (mem_req) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      tmo_cnt_q <= 16'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign state         = state_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;
  assign retired_count = retired_q;

endmodule
